ocl_axil_arbiter: RTL

- Shares the single AXI-Lite register slave (hello-world/VLED register block behind the OCL register slice) between NUM_M AXI-Lite masters: PCIe OCL (master 0) and on-chip/debug masters (1..NUM_M-1).
- Round-robin arbitration, one transaction (read or write) outstanding at a time.
- Responses are routed back to the granted master only.
- Sits between the OCL register slice output and the CL register decode logic, in the clk_main_a0 domain.

---
 rtl/ocl_axil_arbiter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ocl_axil_arbiter.sv
// Round-robin AXI-Lite arbiter: NUM_M masters share one register slave, one
// transaction in flight at a time, responses steered back to the granted master.
module ocl_axil_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk_main_a0,
  input  logic                       rst_main_sync,
  input  logic [NUM_M-1:0]           s_awvalid,
  output logic [NUM_M-1:0]           s_awready,
  input  logic [NUM_M*ADDR_W-1:0]    s_awaddr,
  input  logic [NUM_M-1:0]           s_wvalid,
  output logic [NUM_M-1:0]           s_wready,
  input  logic [NUM_M*DATA_W-1:0]    s_wdata,
  input  logic [NUM_M*DATA_W/8-1:0]  s_wstrb,
  output logic [NUM_M-1:0]           s_bvalid,
  input  logic [NUM_M-1:0]           s_bready,
  output logic [NUM_M*2-1:0]         s_bresp,
  input  logic [NUM_M-1:0]           s_arvalid,
  output logic [NUM_M-1:0]           s_arready,
  input  logic [NUM_M*ADDR_W-1:0]    s_araddr,
  output logic [NUM_M-1:0]           s_rvalid,
  input  logic [NUM_M-1:0]           s_rready,
  output logic [NUM_M*DATA_W-1:0]    s_rdata,
  output logic [NUM_M*2-1:0]         s_rresp,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [ADDR_W-1:0]          m_awaddr,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  input  logic [1:0]                 m_bresp,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  output logic [ADDR_W-1:0]          m_araddr,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  input  logic [DATA_W-1:0]          m_rdata,
  input  logic [1:0]                 m_rresp,
  output logic [1:0]                 grant_id,
  output logic                       busy
);

  localparam int STRB_W = DATA_W/8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_FWD,
    S_WR_RESP,
    S_RD_FWD,
    S_RD_RESP
  } state_t;

  state_t      r_state;
  logic [1:0]  r_grant;
  logic [1:0]  r_rr_ptr;
  logic        r_aw_done;
  logic        r_w_done;

  logic [NUM_M-1:0]  w_req;
  logic              w_found;
  logic [1:0]        w_win;
  logic              w_win_wr;

  logic              w_g_awvalid;
  logic              w_g_wvalid;
  logic              w_g_arvalid;
  logic              w_g_bready;
  logic              w_g_rready;
  logic [ADDR_W-1:0] w_g_awaddr;
  logic [ADDR_W-1:0] w_g_araddr;
  logic [DATA_W-1:0] w_g_wdata;
  logic [STRB_W-1:0] w_g_wstrb;

  logic w_wr_fwd;
  logic w_wr_resp;
  logic w_rd_fwd;
  logic w_rd_resp;
  logic w_aw_fire;
  logic w_w_fire;

  assign w_req = s_awvalid | s_arvalid;

  // Two passes give the wrap-around scan: indices at/above rr_ptr first, then the rest.
  always_comb begin
    w_found  = 1'b0;
    w_win    = '0;
    w_win_wr = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (!w_found && w_req[i] && (2'(i) >= r_rr_ptr)) begin
        w_found  = 1'b1;
        w_win    = 2'(i);
        w_win_wr = s_awvalid[i];
      end
    end
    for (int i = 0; i < NUM_M; i++) begin
      if (!w_found && w_req[i]) begin
        w_found  = 1'b1;
        w_win    = 2'(i);
        w_win_wr = s_awvalid[i];
      end
    end
  end

  always_comb begin
    w_g_awvalid = 1'b0;
    w_g_wvalid  = 1'b0;
    w_g_arvalid = 1'b0;
    w_g_bready  = 1'b0;
    w_g_rready  = 1'b0;
    w_g_awaddr  = '0;
    w_g_araddr  = '0;
    w_g_wdata   = '0;
    w_g_wstrb   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_grant == 2'(i)) begin
        w_g_awvalid = s_awvalid[i];
        w_g_wvalid  = s_wvalid[i];
        w_g_arvalid = s_arvalid[i];
        w_g_bready  = s_bready[i];
        w_g_rready  = s_rready[i];
        w_g_awaddr  = s_awaddr[i*ADDR_W +: ADDR_W];
        w_g_araddr  = s_araddr[i*ADDR_W +: ADDR_W];
        w_g_wdata   = s_wdata[i*DATA_W +: DATA_W];
        w_g_wstrb   = s_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  assign w_wr_fwd  = (r_state == S_WR_FWD);
  assign w_wr_resp = (r_state == S_WR_RESP);
  assign w_rd_fwd  = (r_state == S_RD_FWD);
  assign w_rd_resp = (r_state == S_RD_RESP);

  // Each write channel is masked once its own handshake has happened.
  assign m_awvalid = w_wr_fwd & ~r_aw_done & w_g_awvalid;
  assign m_wvalid  = w_wr_fwd & ~r_w_done & w_g_wvalid;
  assign m_awaddr  = w_g_awaddr;
  assign m_wdata   = w_g_wdata;
  assign m_wstrb   = w_g_wstrb;
  assign m_bready  = w_wr_resp & w_g_bready;
  assign m_arvalid = w_rd_fwd & w_g_arvalid;
  assign m_araddr  = w_g_araddr;
  assign m_rready  = w_rd_resp & w_g_rready;

  assign w_aw_fire = m_awvalid & m_awready;
  assign w_w_fire  = m_wvalid & m_wready;

  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_arready = '0;
    s_bvalid  = '0;
    s_rvalid  = '0;
    s_bresp   = '0;
    s_rresp   = '0;
    s_rdata   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_grant == 2'(i)) begin
        s_awready[i] = w_wr_fwd & ~r_aw_done & m_awready;
        s_wready[i]  = w_wr_fwd & ~r_w_done & m_wready;
        s_arready[i] = w_rd_fwd & m_arready;
        s_bvalid[i]  = w_wr_resp & m_bvalid;
        s_rvalid[i]  = w_rd_resp & m_rvalid;
        if (w_wr_resp) begin
          s_bresp[i*2 +: 2] = m_bresp;
        end
        if (w_rd_resp) begin
          s_rresp[i*2 +: 2]          = m_rresp;
          s_rdata[i*DATA_W +: DATA_W] = m_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant   <= w_win;
            r_rr_ptr  <= (w_win == 2'(NUM_M-1)) ? 2'd0 : w_win + 2'd1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= w_win_wr ? S_WR_FWD : S_RD_FWD;
          end
        end
        S_WR_FWD: begin
          if ((r_aw_done | w_aw_fire) & (r_w_done | w_w_fire)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= S_WR_RESP;
          end else begin
            r_aw_done <= r_aw_done | w_aw_fire;
            r_w_done  <= r_w_done | w_w_fire;
          end
        end
        S_WR_RESP: begin
          if (m_bvalid & m_bready) r_state <= S_IDLE;
        end
        S_RD_FWD: begin
          if (m_arvalid & m_arready) r_state <= S_RD_RESP;
        end
        S_RD_RESP: begin
          if (m_rvalid & m_rready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_id = r_grant;
  assign busy     = (r_state != S_IDLE);

endmodule
